// File: rtl/pmem_fetch_arbiter.sv
// Round-robin arbiter sharing one program-memory read port between NUM_CORES instruction fetchers.
// Optional sticky bursts per core are enabled with the PMEM_ARB_BURST_EN macro.
module pmem_fetch_arbiter #(
    parameter int NUM_CORES             = 4,
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int PROGRAM_MEM_DATA_BITS = 16,
    parameter int MAX_BURST             = 4,
    localparam int GW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [NUM_CORES-1:0]                       core_read_valid,
    input  logic [NUM_CORES*PROGRAM_MEM_ADDR_BITS-1:0] core_read_address,
    output logic [NUM_CORES-1:0]                       core_read_ready,
    output logic [PROGRAM_MEM_DATA_BITS-1:0]           core_read_data,
    output logic                                       mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0]           mem_read_address,
    input  logic                                       mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0]           mem_read_data,
    output logic [GW-1:0]                              grant_id,
    output logic                                       busy
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    if (NUM_CORES < 2 || NUM_CORES > 16 || MAX_BURST < 1 || MAX_BURST > 15) begin : g_param_check
        $error("pmem_fetch_arbiter: parameter out of range");
    end

    state_t        state;
    logic [GW-1:0] last_grant;
    logic [GW-1:0] rr_winner;
    logic [GW-1:0] winner;
    logic          any_req;

    assign any_req = |core_read_valid;

    // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        logic          found;
        logic [GW-1:0] cand;
        found     = 1'b0;
        cand      = '0;
        rr_winner = '0;
        // Search starts just after the last winner and wraps, giving rotating priority.
        for (int i = 1; i <= NUM_CORES; i++) begin
            cand = GW'((int'(last_grant) + i) % NUM_CORES);
            if (!found && core_read_valid[cand]) begin
                found     = 1'b1;
                rr_winner = cand;
            end
        end
    end

`ifdef PMEM_ARB_BURST_EN
    logic [3:0] burst_count;
    logic       stick;

    // A zero count means no burst is running, so the reset value of last_grant never sticks.
    assign stick  = (burst_count != 4'd0) && (burst_count < 4'(MAX_BURST))
                    && core_read_valid[last_grant];
    assign winner = stick ? last_grant : rr_winner;
`else
    assign winner = rr_winner;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            mem_read_valid   <= 1'b0;
            mem_read_address <= '0;
            core_read_ready  <= '0;
            core_read_data   <= '0;
            grant_id         <= '0;
            busy             <= 1'b0;
            last_grant       <= GW'(NUM_CORES - 1);
`ifdef PMEM_ARB_BURST_EN
            burst_count      <= 4'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_id         <= winner;
                        mem_read_address <= core_read_address[int'(winner)*PROGRAM_MEM_ADDR_BITS +: PROGRAM_MEM_ADDR_BITS];
                        mem_read_valid   <= 1'b1;
                        busy             <= 1'b1;
                        state            <= REQ;
                    end
`ifdef PMEM_ARB_BURST_EN
                    if (any_req)
                        burst_count <= stick ? burst_count + 4'd1 : 4'd1;
                    else
                        burst_count <= 4'd0;
`endif
                end
                REQ: begin
                    // The granted core may have dropped its request; the transfer still completes.
                    if (mem_read_ready) begin
                        core_read_data  <= mem_read_data;
                        mem_read_valid  <= 1'b0;
                        core_read_ready <= NUM_CORES'(1) << grant_id;
                        last_grant      <= grant_id;
                        state           <= RESP;
                    end
                end
                RESP: begin
                    core_read_ready <= '0;
                    busy            <= 1'b0;
                    state           <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pmem_fetch_arbiter.sv
// Directed bench for pmem_fetch_arbiter: single read, round-robin, wait states, async reset, dropped request.
// With PMEM_ARB_BURST_EN defined the round-robin section is replaced by the MAX_BURST=2 burst sequence.
module tb_pmem_fetch_arbiter;

    localparam int N  = 4;
    localparam int A  = 8;
    localparam int D  = 16;
    localparam int GW = 2;

    logic           clk;
    logic           reset;
    logic [N-1:0]   core_read_valid;
    logic [N*A-1:0] core_read_address;
    logic [N-1:0]   core_read_ready;
    logic [D-1:0]   core_read_data;
    logic           mem_read_valid;
    logic [A-1:0]   mem_read_address;
    logic           mem_read_ready;
    logic [D-1:0]   mem_read_data;
    logic [GW-1:0]  grant_id;
    logic           busy;

    int test_count = 0;
    int fail_count = 0;

    pmem_fetch_arbiter #(
        .NUM_CORES(N), .PROGRAM_MEM_ADDR_BITS(A), .PROGRAM_MEM_DATA_BITS(D), .MAX_BURST(2)
    ) dut (
        .clk(clk), .reset(reset),
        .core_read_valid(core_read_valid), .core_read_address(core_read_address),
        .core_read_ready(core_read_ready), .core_read_data(core_read_data),
        .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
        .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
        .grant_id(grant_id), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        test_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    // Entered in the first REQ cycle; leaves in the IDLE cycle following RESP.
    task automatic xfer(input int core, input logic [A-1:0] addr, input logic [D-1:0] data, input int waits);
        for (int w = 0; w <= waits; w++) begin
            check("req_valid", 32'(mem_read_valid), 32'd1);
            check("req_addr", 32'(mem_read_address), 32'(addr));
            check("req_grant", 32'(grant_id), 32'(core));
            check("req_no_ready", 32'(core_read_ready), 32'd0);
            check("req_busy", 32'(busy), 32'd1);
            if (w == waits) begin
                mem_read_ready = 1'b1;
                mem_read_data  = data;
            end
            tick();
        end
        mem_read_ready = 1'b0;
        mem_read_data  = '0;
        check("rsp_ready", 32'(core_read_ready), 32'(1) << core);
        check("rsp_data", 32'(core_read_data), 32'(data));
        check("rsp_mem_valid", 32'(mem_read_valid), 32'd0);
        check("rsp_busy", 32'(busy), 32'd1);
        tick();
        check("idle_ready", 32'(core_read_ready), 32'd0);
        check("idle_data_held", 32'(core_read_data), 32'(data));
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int seq [6];
        reset             = 1'b0;
        core_read_valid   = '0;
        core_read_address = '0;
        mem_read_ready    = 1'b0;
        mem_read_data     = '0;

        #3;
        check("rst_mem_valid", 32'(mem_read_valid), 32'd0);
        check("rst_mem_addr", 32'(mem_read_address), 32'd0);
        check("rst_ready", 32'(core_read_ready), 32'd0);
        check("rst_data", 32'(core_read_data), 32'd0);
        check("rst_grant", 32'(grant_id), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        tick();
        tick();
        reset = 1'b1;

        // Single request from core 2, zero-wait memory.
        core_read_valid[2]         = 1'b1;
        core_read_address[2*A +: A] = 8'h15;
        tick();
        core_read_valid = '0;
        xfer(2, 8'h15, 16'hBEEF, 0);

        do_reset();
`ifdef PMEM_ARB_BURST_EN
        // Cores 1 and 3 request continuously; each gets two grants in a row.
        core_read_valid             = 4'b1010;
        core_read_address[1*A +: A] = 8'h21;
        core_read_address[3*A +: A] = 8'h23;
        seq = '{1, 1, 3, 3, 1, 1};
        for (int i = 0; i < 6; i++) begin
            tick();
            xfer(seq[i], (seq[i] == 1) ? 8'h21 : 8'h23, 16'hB000 + 16'(i), 0);
        end
        core_read_valid = '0;
`else
        // All cores request continuously; grants rotate 0,1,2,3,0.
        seq = '{0, 1, 2, 3, 0, 0};
        core_read_valid = 4'b1111;
        for (int c = 0; c < N; c++) core_read_address[c*A +: A] = 8'h10 + 8'(c);
        for (int i = 0; i < 5; i++) begin
            tick();
            xfer(seq[i], 8'h10 + 8'(seq[i]), 16'hA000 + 16'(i), 0);
        end
        core_read_valid = '0;
`endif

        // Wait states: core 1 with five memory wait cycles.
        core_read_valid[1]          = 1'b1;
        core_read_address[1*A +: A] = 8'h33;
        tick();
        core_read_valid = '0;
        xfer(1, 8'h33, 16'h1234, 5);

        // Async reset while core 3's read is waiting on memory.
        core_read_valid             = 4'b1000;
        core_read_address[3*A +: A] = 8'h44;
        tick();
        check("pre_rst_valid", 32'(mem_read_valid), 32'd1);
        check("pre_rst_grant", 32'(grant_id), 32'd3);
        tick();
        #2 reset = 1'b0;
        #1;
        check("async_mem_valid", 32'(mem_read_valid), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_ready", 32'(core_read_ready), 32'd0);
        check("async_grant", 32'(grant_id), 32'd0);
        core_read_valid = '0;
        mem_read_ready  = 1'b1;
        mem_read_data   = 16'hDEAD;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("stray_ready", 32'(core_read_ready), 32'd0);
        check("stray_mem_valid", 32'(mem_read_valid), 32'd0);
        check("stray_data", 32'(core_read_data), 32'd0);
        mem_read_ready = 1'b0;
        mem_read_data  = '0;

        // Core 0 gets first priority after reset, then drops its request mid-transfer.
        core_read_valid             = 4'b1001;
        core_read_address[0*A +: A] = 8'h50;
        core_read_address[3*A +: A] = 8'h53;
        tick();
        core_read_valid[0] = 1'b0;
        xfer(0, 8'h50, 16'h5000, 2);
        tick();
        xfer(3, 8'h53, 16'h5003, 0);
        core_read_valid = '0;
        tick();
        check("final_idle_valid", 32'(mem_read_valid), 32'd0);
        check("final_idle_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule

// File: doc/pmem_fetch_arbiter.md
# pmem_fetch_arbiter

Shares one program-memory read port between the instruction fetchers of `NUM_CORES` cores. Each fetcher drives a valid/address request and expects a single-cycle ready pulse with data per transfer. The block grants requesters round-robin, runs one memory read at a time and returns the data to the granted core. It sits between the per-core fetchers and the program-memory controller.

## Interface
- `NUM_CORES`, 4: number of requesting fetchers (2..16).
- `PROGRAM_MEM_ADDR_BITS`, 8: address width.
- `PROGRAM_MEM_DATA_BITS`, 16: instruction width.
- `MAX_BURST`, 4: maximum back-to-back grants to one core (used only with `PMEM_ARB_BURST_EN`; range 1..15).
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset; 0 = reset asserted.
- `core_read_valid`  in  NUM_CORES  per-core request.
- `core_read_address`  in  NUM_CORES*PROGRAM_MEM_ADDR_BITS  per-core address; core i occupies bits [i*A +: A].
- `core_read_ready`  out  NUM_CORES  one-hot completion pulse.
- `core_read_data`  out  PROGRAM_MEM_DATA_BITS  shared return bus; meaningful only while a `core_read_ready` bit is 1.
- `mem_read_valid`  out  1  program-memory request.
- `mem_read_address`  out  PROGRAM_MEM_ADDR_BITS  program-memory address.
- `mem_read_ready`  in  1  memory completion; `mem_read_data` is valid in the same cycle.
- `mem_read_data`  in  PROGRAM_MEM_DATA_BITS  memory read data.
- `grant_id`  out  $clog2(NUM_CORES)  index of the core currently or last granted.
- `busy`  out  1  1 in REQ or RESP.

## Operation
- State machine: IDLE → REQ → RESP → IDLE.
- IDLE: if any `core_read_valid` bit is 1, pick a winner round-robin. The search starts at `last_grant+1` and wraps modulo NUM_CORES. Latch `grant_id`, drive `mem_read_address` with the winner's address, set `mem_read_valid`=1, go to REQ.
- REQ: hold `mem_read_valid` and `mem_read_address` stable until `mem_read_ready`=1. At that edge:
  - latch `mem_read_data` into `core_read_data`;
  - clear `mem_read_valid`;
  - set `core_read_ready[grant_id]`=1;
  - update `last_grant`;
  - go to RESP.
- RESP: at the next edge clear `core_read_ready` and go to IDLE. `core_read_data` holds its value until the next completion.
- No arbitration in RESP. Requesters update their address at the ready edge, so the new address is first sampled in IDLE.
- A core that drops `core_read_valid` while granted does not abort the transfer. The transfer completes and the ready pulse is still issued.
- `core_read_ready` is always one-hot or zero.
- Reset (async) values:
  - state = IDLE;
  - `mem_read_valid`=0, `mem_read_address`=0;
  - `core_read_ready`=0, `core_read_data`=0;
  - `grant_id`=0, `busy`=0;
  - `last_grant`=NUM_CORES-1, so core 0 has first priority.
- Reset asserted mid-transfer clears all outputs immediately. Any outstanding memory response after release is ignored, because `mem_read_ready` is only sampled in REQ.

## Timing
- Request sampled in IDLE at cycle 0 → `mem_read_valid`=1 from cycle 1.
- `mem_read_ready` in cycle k → `core_read_ready` pulse in cycle k+1 (exactly one cycle).
- Back-to-back transfers: minimum three cycles per transfer with a zero-wait memory (ready in first REQ cycle). This means memory valid in cycle 1, ready pulse in cycle 2, next grant latched at the end of cycle 3.
- Fairness: with all cores requesting continuously, each core is served once per NUM_CORES transfers.

## Configuration
- `PMEM_ARB_BURST_EN` defined: in IDLE, if the last-granted core still requests and its burst count is below MAX_BURST, that core is re-granted regardless of the others.
  - The burst count increments per consecutive grant.
  - The count resets when another core wins or when the core's request is absent in IDLE.
  - When the count reaches MAX_BURST, normal round-robin resumes from `last_grant+1`.
- Not defined: pure round-robin after every transfer; MAX_BURST is ignored.

## Test plan
- Single request: after reset, core 2 requests address 0x15 and memory answers 0xBEEF in its first REQ cycle → `mem_read_address`=0x15 in cycle 1; `core_read_ready`=4'b0100 with `core_read_data`=0xBEEF in cycle 2 only.
- Round-robin: all 4 cores hold valid with addresses 0x10..0x13 and zero-wait memory → grants go 0,1,2,3,0; each `core_read_ready` pulse is one cycle wide and one-hot.
- Wait states: memory delays ready by 5 cycles → `mem_read_valid` and `mem_read_address` stay stable for all 5 cycles; no ready pulse reaches any core early.
- Async reset in REQ: assert `reset`=0 mid-wait → `mem_read_valid`=0, `busy`=0 and `core_read_ready`=0 immediately. After release, core 0 has first priority.
- Burst (`PMEM_ARB_BURST_EN`, MAX_BURST=2): cores 1 and 3 both continuously valid → grant sequence 0? no (core 0 idle); sequence is 1,1,3,3,1,1.
- Dropped request: core 0 deasserts valid during REQ → the transfer still completes and `core_read_ready[0]` pulses once. Core 0 is not re-granted while its valid is 0.
